// File: rtl/uart_pkg.sv
// Shared UART types and constants, reused by the TX path and a future RX path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int DEFAULT_DIV = 100;
  localparam int FRAME_BITS  = 10;
  localparam int DIV_MIN     = 2;

  // A bit shorter than DIV_MIN clocks cannot be produced by the down-counter.
  function automatic logic [31:0] eff_div(input logic [31:0] div);
    return (div < 32'(DIV_MIN)) ? 32'(DIV_MIN) : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push is ignored when full, pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO, programmable bit divider, frame FSM.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) held for one bit period
// DATA  | eight data bits, LSB first, one bit period each
// STOP  | stop bit (high); chains straight into START when another byte waits
module uart_tx_fifo #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    div_we,
  input  logic [31:0]                   div_di,
  output logic [31:0]                   div_do,
  input  logic                          dat_we,
  input  logic [7:0]                    dat_di,
  output logic                          dat_wait,
  output logic                          ser_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  import uart_pkg::tx_state_t;
  import uart_pkg::IDLE;
  import uart_pkg::START;
  import uart_pkg::DATA;
  import uart_pkg::STOP;
  import uart_pkg::FRAME_BITS;
  import uart_pkg::eff_div;

  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

  tx_state_t   state;
  logic [31:0] div_reg;
  logic [31:0] frame_div;
  logic [31:0] div_cnt;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic [7:0]  head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        bit_done;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (dat_we),
    .push_data (dat_di),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign div_do   = div_reg;
  assign dat_wait = fifo_full;
  assign tx_busy  = (fifo_level != '0) || (state != IDLE);
  assign bit_done = (div_cnt == '0);

  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) pop = (state == IDLE) || (state == STOP && bit_done);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg <= 32'(DEFAULT_DIV);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (div_we[i]) div_reg[8*i +: 8] <= div_di[8*i +: 8];
      end
    end
  end

  // Divider is sampled once per frame so bus writes never stretch a frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ser_tx    <= 1'b1;
      shift     <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      frame_div <= 32'(DEFAULT_DIV);
    end else if (pop) begin
      state     <= START;
      ser_tx    <= 1'b0;
      shift     <= head;
      bit_cnt   <= '0;
      frame_div <= eff_div(div_reg);
      div_cnt   <= eff_div(div_reg) - 32'd1;
    end else begin
      case (state)
        IDLE: ser_tx <= 1'b1;
        START: begin
          if (bit_done) begin
            state   <= DATA;
            ser_tx  <= shift[0];
            div_cnt <= frame_div - 32'd1;
          end else begin
            div_cnt <= div_cnt - 32'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            div_cnt <= frame_div - 32'd1;
            if (bit_cnt == LAST_BIT) begin
              state  <= STOP;
              ser_tx <= 1'b1;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              ser_tx  <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            div_cnt <= div_cnt - 32'd1;
          end
        end
        STOP: begin
          if (bit_done) state   <= IDLE;
          else          div_cnt <= div_cnt - 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: stimulus queues expected frames, a line monitor decodes and compares.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  div_we = '0;
  logic [31:0] div_di = '0;
  logic [31:0] div_do;
  logic        dat_we = 1'b0;
  logic [7:0]  dat_di = '0;
  logic        dat_wait;
  logic        ser_tx;
  logic        tx_busy;
  logic [4:0]  fifo_level;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(100)) dut (
    .clk        (clk),
    .reset      (reset),
    .div_we     (div_we),
    .div_di     (div_di),
    .div_do     (div_do),
    .dat_we     (dat_we),
    .dat_di     (dat_di),
    .dat_wait   (dat_wait),
    .ser_tx     (ser_tx),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  exp_t        exp_q[$];
  int          starts[$];
  int          frames_done = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  string       rx_str = "";
  logic [31:0] div_model = 32'd100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int eff(input logic [31:0] d);
    return (d < 32'd2) ? 2 : int'(d);
  endfunction

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic write_div(input logic [3:0] we, input logic [31:0] d);
    div_we = we;
    div_di = d;
    @(negedge clk);
    div_we = '0;
    for (int i = 0; i < 4; i++) if (we[i]) div_model[8*i +: 8] = d[8*i +: 8];
    chk("div_readback", div_do, div_model);
  endtask

  // Bus master: holds the byte until dat_wait is low, then it is taken at the next edge.
  task automatic push_seq(input logic [7:0] b, output int acc);
    exp_t e;
    int n = 0;
    dat_di = b;
    dat_we = 1'b1;
    while (dat_wait && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("push_timeout", dat_wait, 1'b0);
    @(negedge clk);
    acc = cyc;
    e.data = b;
    e.div  = eff(div_model);
    exp_q.push_back(e);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frames_completed", frames_done, target);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (starts.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_started", starts.size(), target);
  endtask

  task automatic idle_check(input string name, input int len);
    int bad = 0;
    repeat (len) begin
      @(negedge clk);
      if (ser_tx !== 1'b1) bad++;
    end
    chk(name, bad, 0);
  endtask

  // Line monitor: every frame must be 10 bit periods of the queued divider, bit-exact per clock.
  initial begin : monitor
    exp_t       e;
    logic [7:0] got;
    logic       expbit;
    logic       shape_ok;
    logic       aborted;
    int         k;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (ser_tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", ser_tx, 1'b1);
          while (ser_tx !== 1'b1 && !reset) @(negedge clk);
        end else begin
          e = exp_q.pop_front();
          starts.push_back(cyc);
          shape_ok = 1'b1;
          aborted  = 1'b0;
          got      = '0;
          for (int i = 0; i < 10 * e.div; i++) begin
            if (i > 0) @(negedge clk);
            if (reset) begin
              aborted = 1'b1;
              break;
            end
            k = i / e.div;
            if (k == 0)      expbit = 1'b0;
            else if (k == 9) expbit = 1'b1;
            else             expbit = e.data[k-1];
            if (ser_tx !== expbit) shape_ok = 1'b0;
            if (k >= 1 && k <= 8 && (i % e.div) == e.div / 2) got[k-1] = ser_tx;
          end
          if (!aborted) begin
            chk("frame_shape", {31'd0, shape_ok}, 32'd1);
            chk("frame_data", {24'd0, got}, {24'd0, e.data});
            rx_str = $sformatf("%s%c", rx_str, got);
            frames_done++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         acc, p0, s, prev, stalls, f0, nb, bad, gap;
    logic [7:0] b;
    logic [3:0] we;
    logic [31:0] d;

    // Reset and idle line
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ser_tx", ser_tx, 1'b1);
    chk("rst_div_do", div_do, 32'd100);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_wait", dat_wait, 1'b0);
    idle_check("rst_idle_line", 200);

    // Single byte at the default divider
    starts.delete();
    f0 = frames_done;
    push_seq(8'h41, acc);
    dat_we = 1'b0;
    wait_starts(1, 50);
    if (starts.size() >= 1) begin
      s = starts[0];
      chk("single_latency", s - acc, 1);
      while (cyc < s + 999) @(negedge clk);
      chk("single_busy_last_clk", tx_busy, 1'b1);
      @(negedge clk);
      chk("single_busy_drop", tx_busy, 1'b0);
    end
    wait_frames(f0 + 1, 1100);

    // Back-to-back frames
    starts.delete();
    f0 = frames_done;
    rx_str = "";
    push_seq(8'h48, acc);
    push_seq(8'h69, acc);
    push_seq(8'h0A, acc);
    dat_we = 1'b0;
    wait_frames(f0 + 3, 3500);
    chk("hi_frames", starts.size(), 3);
    if (starts.size() == 3) begin
      chk("hi_gap_1", starts[1] - starts[0], 1000);
      chk("hi_gap_2", starts[2] - starts[1], 1000);
    end
    $display("rx text: %s", rx_str);
    chk("hi_text", {31'd0, rx_str == "Hi\n"}, 32'd1);

    // Fill the FIFO while the first frame is on the line
    starts.delete();
    f0 = frames_done;
    push_seq(8'h30, p0);
    prev = p0;
    stalls = 0;
    for (int i = 1; i <= 16; i++) begin
      b = 8'(8'h30 + i);
      push_seq(b, acc);
      if (acc != prev + 1) stalls++;
      prev = acc;
    end
    chk("full_no_stall", stalls, 0);
    dat_di = 8'h41;
    dat_we = 1'b1;
    chk("full_level", fifo_level, DEPTH);
    chk("full_wait", dat_wait, 1'b1);
    push_seq(8'h41, acc);
    dat_we = 1'b0;
    chk("full_accept_cycle", acc, p0 + 1002);
    chk("full_level_refill", fifo_level, DEPTH);
    wait_frames(f0 + 18, 19000);
    chk("full_frames", starts.size(), 18);
    bad = 0;
    for (int i = 1; i < starts.size(); i++) if (starts[i] - starts[i-1] != 1000) bad++;
    chk("full_contiguous", bad, 0);

    // Divider change mid-frame only affects the next frame
    starts.delete();
    f0 = frames_done;
    push_seq(8'h5A, acc);
    dat_we = 1'b0;
    wait_starts(1, 50);
    if (starts.size() >= 1) begin
      s = starts[0];
      while (cyc < s + 300) @(negedge clk);
    end
    write_div(4'b0001, {$urandom_range(0, 32'hFFFFFF) , 8'd0} | 32'd20);
    chk("div_is_20", div_do, 32'd20);
    push_seq(8'hC3, acc);
    dat_we = 1'b0;
    wait_frames(f0 + 2, 2000);
    if (starts.size() >= 2) chk("div_next_frame_start", starts[1] - starts[0], 1000);
    f0 = frames_done;
    write_div(4'b0001, 32'd1);
    push_seq(8'h96, acc);
    dat_we = 1'b0;
    wait_frames(f0 + 1, 100);

    // Random divider readback, then random bytes at random dividers
    repeat (4) begin
      we = 4'($urandom_range(0, 15));
      d  = $urandom();
      write_div(we, d);
    end
    repeat (3) begin
      write_div(4'b1111, $urandom_range(1, 12));
      f0 = frames_done;
      nb = $urandom_range(2, 4);
      for (int i = 0; i < nb; i++) begin
        gap = $urandom_range(0, 3);
        dat_we = 1'b0;
        repeat (gap) @(negedge clk);
        push_seq(8'($urandom_range(0, 255)), acc);
      end
      dat_we = 1'b0;
      wait_frames(f0 + nb, 800);
    end

    // Reset during data bit 4 of 0x55, with a second byte still queued
    write_div(4'b1111, 32'd60);
    starts.delete();
    f0 = frames_done;
    push_seq(8'h55, acc);
    push_seq(8'h33, acc);
    dat_we = 1'b0;
    wait_starts(1, 50);
    if (starts.size() >= 1) begin
      s = starts[0];
      while (cyc < s + 5 * 60 + 30) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    chk("midrst_ser_tx", ser_tx, 1'b1);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_busy", tx_busy, 1'b0);
    chk("midrst_div_do", div_do, 32'd100);
    exp_q.delete();
    div_model = 32'd100;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle_check("midrst_idle_line", 200);
    chk("midrst_no_frames", frames_done, f0);

    // Reset while the line is low must raise it without waiting for a clock
    starts.delete();
    push_seq(8'hF0, acc);
    dat_we = 1'b0;
    wait_starts(1, 50);
    repeat (10) @(negedge clk);
    #2;
    chk("startrst_line_low", ser_tx, 1'b0);
    reset = 1'b1;
    #1;
    chk("startrst_ser_tx", ser_tx, 1'b1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle_check("startrst_idle_line", 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
